// File: rtl/ctrl_pkg.sv
// Shared definitions for the registered RV32I control decoder.
// Bundle bit map (LSB first): 0 reg_write, 1 alu_src_a, 2 alu_src_b, 3 mem_wr,
// 4 mem_rd, 5 branch, 6 mem_to_reg, 7 jal, 8 imm_to_reg, 9 pc_to_reg,
// 10 cmp_branch, 11 ILL, 12 SYS.
package ctrl_pkg;

  localparam int unsigned CTRL_W = 13;
  localparam int unsigned B_ILL  = 11;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_FENCE  = 7'b0001111,
    OP_OPIMM  = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_OP     = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111,
    OP_SYSTEM = 7'b1110011
  } opcode_e;

  localparam logic [CTRL_W-1:0] CTRL_JAL    = 13'h02A7;
  localparam logic [CTRL_W-1:0] CTRL_LUI    = 13'h0105;
  localparam logic [CTRL_W-1:0] CTRL_AUIPC  = 13'h0007;
  localparam logic [CTRL_W-1:0] CTRL_BRANCH = 13'h0426;
  localparam logic [CTRL_W-1:0] CTRL_STORE  = 13'h000C;
  localparam logic [CTRL_W-1:0] CTRL_LOAD   = 13'h0055;
  localparam logic [CTRL_W-1:0] CTRL_OPIMM  = 13'h0005;
  localparam logic [CTRL_W-1:0] CTRL_OP     = 13'h0001;
  localparam logic [CTRL_W-1:0] CTRL_SYS    = 13'h1000;
  localparam logic [CTRL_W-1:0] CTRL_ILL    = 13'h0800;

endpackage

// File: rtl/ctrl_decode_lane.sv
// Combinational opcode -> control bundle for one lane.
// Ports:
//   i_opcode  7-bit RV32I major opcode
//   o_ctrl    CTRL_W-bit control bundle; unknown opcodes give the ILL-only bundle
module ctrl_decode_lane
  import ctrl_pkg::*;
#(
  parameter bit EN_SYSTEM = 1'b0
) (
  input  logic [6:0]        i_opcode,
  output logic [CTRL_W-1:0] o_ctrl
);

  always_comb begin
    o_ctrl = CTRL_ILL;
    case (i_opcode)
      OP_JAL, OP_JALR:      o_ctrl = CTRL_JAL;
      OP_LUI:               o_ctrl = CTRL_LUI;
      OP_AUIPC:             o_ctrl = CTRL_AUIPC;
      OP_BRANCH:            o_ctrl = CTRL_BRANCH;
      OP_STORE:             o_ctrl = CTRL_STORE;
      OP_LOAD:              o_ctrl = CTRL_LOAD;
      OP_OPIMM:             o_ctrl = CTRL_OPIMM;
      OP_OP:                o_ctrl = CTRL_OP;
      OP_FENCE, OP_SYSTEM:  o_ctrl = EN_SYSTEM ? CTRL_SYS : CTRL_ILL;
      default:              o_ctrl = CTRL_ILL;
    endcase
  end

endmodule

// File: rtl/ctrl_decode_pipe.sv
// Registered, flow-controlled control decoder: LANES opcodes per beat are
// decoded and stored in a 2-entry FIFO skid buffer with valid/ready on both
// sides; a saturating counter tracks illegal lanes accepted since reset.
// Ports:
//   clk_w_i, rst_w_i_l          clock / async active-low reset
//   flush_w_i_h                 synchronous discard of all buffered beats
//   in_valid_w_i_h/in_ready_w_o_h/in_opcode_w_i      upstream beat (7 bits per lane)
//   out_valid_w_o_h/out_ready_w_i_h/out_ctrl_w_o     downstream beat (13 bits per lane)
//   out_illegal_w_o_h           any lane of the presented beat is illegal
//   ill_cnt_w_o                 saturating count of accepted illegal lanes
module ctrl_decode_pipe
  import ctrl_pkg::*;
#(
  parameter int unsigned LANES     = 1,
  parameter bit          EN_SYSTEM = 1'b0,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                      clk_w_i,
  input  logic                      rst_w_i_l,
  input  logic                      flush_w_i_h,
  input  logic                      in_valid_w_i_h,
  output logic                      in_ready_w_o_h,
  input  logic [7*LANES-1:0]        in_opcode_w_i,
  output logic                      out_valid_w_o_h,
  input  logic                      out_ready_w_i_h,
  output logic [CTRL_W*LANES-1:0]   out_ctrl_w_o,
  output logic                      out_illegal_w_o_h,
  output logic [CNT_W-1:0]          ill_cnt_w_o
);

  logic [CTRL_W*LANES-1:0] w_dec;
  logic [CTRL_W*LANES-1:0] r_mem [2];
  logic                    r_wr_ptr;
  logic                    r_rd_ptr;
  logic [1:0]              r_count;
  logic [1:0]              w_count_next;
  logic                    r_in_ready;
  logic [CNT_W-1:0]        r_ill_cnt;
  logic [CNT_W-1:0]        w_ill_next;
  logic [2:0]              w_ill_num;
  logic [CNT_W+2:0]        w_ill_sum;
  logic                    w_accept;
  logic                    w_pop;
  logic                    w_out_valid;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    ctrl_decode_lane #(.EN_SYSTEM(EN_SYSTEM)) u_lane (
      .i_opcode (in_opcode_w_i[7*k +: 7]),
      .o_ctrl   (w_dec[CTRL_W*k +: CTRL_W])
    );
  end

  assign w_out_valid = (r_count != 2'd0);
  assign w_accept    = in_valid_w_i_h & r_in_ready;
  assign w_pop       = w_out_valid & out_ready_w_i_h;

  always_comb begin
    w_count_next = r_count;
    case ({w_accept, w_pop})
      2'b10:   w_count_next = r_count + 2'd1;
      2'b01:   w_count_next = r_count - 2'd1;
      default: w_count_next = r_count;
    endcase
  end

  always_comb begin
    w_ill_num = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      w_ill_num = w_ill_num + 3'(w_dec[CTRL_W*k + B_ILL]);
    end
    w_ill_sum  = (CNT_W+3)'(r_ill_cnt) + (CNT_W+3)'(w_ill_num);
    w_ill_next = (w_ill_sum > (CNT_W+3)'({CNT_W{1'b1}})) ? '1 : w_ill_sum[CNT_W-1:0];
  end

  // in_ready is registered from the next-state count so it never depends
  // combinationally on in_valid.
  always_ff @(posedge clk_w_i or negedge rst_w_i_l) begin
    if (!rst_w_i_l) begin
      r_mem      <= '{default: '0};
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
      r_in_ready <= 1'b0;
      r_ill_cnt  <= '0;
    end else if (flush_w_i_h) begin
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
      r_in_ready <= 1'b1;
    end else begin
      if (w_accept) begin
        r_mem[r_wr_ptr] <= w_dec;
        r_wr_ptr        <= ~r_wr_ptr;
        r_ill_cnt       <= w_ill_next;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count    <= w_count_next;
      r_in_ready <= (w_count_next != 2'd2);
    end
  end

  always_comb begin
    out_ctrl_w_o      = w_out_valid ? r_mem[r_rd_ptr] : '0;
    out_illegal_w_o_h = 1'b0;
    for (int unsigned k = 0; k < LANES; k++) begin
      out_illegal_w_o_h = out_illegal_w_o_h | out_ctrl_w_o[CTRL_W*k + B_ILL];
    end
  end

  assign in_ready_w_o_h  = r_in_ready;
  assign out_valid_w_o_h = w_out_valid;
  assign ill_cnt_w_o     = r_ill_cnt;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Directed bench: instance A (LANES=1, EN_SYSTEM=0, CNT_W=2) and
// instance B (LANES=4, EN_SYSTEM=1, CNT_W=8) share clock and reset.
module tb_ctrl_decode_pipe;

  logic        clk;
  logic        rst_n;

  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_illegal;
  logic [6:0]  a_op;
  logic [12:0] a_ctrl;
  logic [1:0]  a_cnt;

  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_illegal;
  logic [27:0] b_op;
  logic [51:0] b_ctrl;
  logic [7:0]  b_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  ctrl_decode_pipe #(.LANES(1), .EN_SYSTEM(1'b0), .CNT_W(2)) u_dut_a (
    .clk_w_i           (clk),
    .rst_w_i_l         (rst_n),
    .flush_w_i_h       (a_flush),
    .in_valid_w_i_h    (a_in_valid),
    .in_ready_w_o_h    (a_in_ready),
    .in_opcode_w_i     (a_op),
    .out_valid_w_o_h   (a_out_valid),
    .out_ready_w_i_h   (a_out_ready),
    .out_ctrl_w_o      (a_ctrl),
    .out_illegal_w_o_h (a_out_illegal),
    .ill_cnt_w_o       (a_cnt)
  );

  ctrl_decode_pipe #(.LANES(4), .EN_SYSTEM(1'b1), .CNT_W(8)) u_dut_b (
    .clk_w_i           (clk),
    .rst_w_i_l         (rst_n),
    .flush_w_i_h       (b_flush),
    .in_valid_w_i_h    (b_in_valid),
    .in_ready_w_o_h    (b_in_ready),
    .in_opcode_w_i     (b_op),
    .out_valid_w_o_h   (b_out_valid),
    .out_ready_w_i_h   (b_out_ready),
    .out_ctrl_w_o      (b_ctrl),
    .out_illegal_w_o_h (b_out_illegal),
    .ill_cnt_w_o       (b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_op = '0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_op = '0;

    // Reset values
    #2;
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_in_ready", a_in_ready, 0);
    chk("rst_ctrl", a_ctrl, 0);
    chk("rst_illegal", a_out_illegal, 0);
    chk("rst_cnt", a_cnt, 0);
    chk("rst_b_ctrl", b_ctrl, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", a_in_ready, 1);

    // OP with 1-cycle latency
    a_out_ready = 1'b1; a_in_valid = 1'b1; a_op = 7'b0110011;
    tick();
    chk("op_valid", a_out_valid, 1);
    chk("op_ctrl", a_ctrl, 13'h001);
    chk("op_illegal", a_out_illegal, 0);
    a_in_valid = 1'b0;
    tick();
    chk("op_drained", a_out_valid, 0);

    // Fill to full under backpressure, then release in FIFO order
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_op = 7'b1101111;
    tick();
    chk("fill1_in_ready", a_in_ready, 1);
    a_op = 7'b0000011;
    tick();
    chk("full_in_ready", a_in_ready, 0);
    chk("full_head", a_ctrl, 13'h2A7);
    a_op = 7'b1111111;
    tick();
    chk("full_ignore_cnt", a_cnt, 0);
    chk("full_head_stable", a_ctrl, 13'h2A7);
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    tick();
    chk("pop2_ctrl", a_ctrl, 13'h055);
    chk("pop2_in_ready", a_in_ready, 1);
    tick();
    chk("empty_valid", a_out_valid, 0);
    chk("empty_ctrl", a_ctrl, 0);

    // Illegal opcodes, SYSTEM with EN_SYSTEM=0
    a_in_valid = 1'b1; a_op = 7'b1111111;
    tick();
    a_in_valid = 1'b0;
    chk("ill_ctrl", a_ctrl, 13'h800);
    chk("ill_flag", a_out_illegal, 1);
    chk("ill_cnt1", a_cnt, 1);
    tick();
    a_in_valid = 1'b1; a_op = 7'b1110011;
    tick();
    a_in_valid = 1'b0;
    chk("sys_off_ctrl", a_ctrl, 13'h800);
    chk("sys_off_cnt", a_cnt, 2);
    tick();

    // Flush with full buffer and a beat offered
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_op = 7'b0110011;
    tick();
    tick();
    chk("pre_flush_ready", a_in_ready, 0);
    a_op = 7'b1111111; a_flush = 1'b1;
    tick();
    a_flush = 1'b0; a_in_valid = 1'b0;
    chk("flush_valid", a_out_valid, 0);
    chk("flush_in_ready", a_in_ready, 1);
    chk("flush_ctrl", a_ctrl, 0);
    chk("flush_cnt", a_cnt, 2);
    a_out_ready = 1'b1;
    tick();
    chk("flush_lost", a_out_valid, 0);

    // Saturation at 3 with CNT_W=2
    a_in_valid = 1'b1; a_op = 7'b1111111;
    repeat (5) tick();
    a_in_valid = 1'b0;
    chk("sat_cnt", a_cnt, 3);
    chk("sat_ctrl", a_ctrl, 13'h800);
    tick();
    chk("sat_hold", a_cnt, 3);
    chk("sat_drained", a_out_valid, 0);

    // Four-lane beats with EN_SYSTEM=1
    b_out_ready = 1'b1; b_in_valid = 1'b1;
    b_op = {7'b0010111, 7'b1100011, 7'b0100011, 7'b0110111};
    tick();
    chk("b_mix_ctrl", b_ctrl, {13'h007, 13'h426, 13'h00C, 13'h105});
    chk("b_mix_illegal", b_out_illegal, 0);
    b_op = {7'b0001111, 7'b0001111, 7'b0001111, 7'b0001111};
    tick();
    chk("b_fence_ctrl", b_ctrl, {13'h1000, 13'h1000, 13'h1000, 13'h1000});
    chk("b_fence_cnt", b_cnt, 0);
    chk("b_fence_illegal", b_out_illegal, 0);
    b_op = {7'b0001111, 7'b1110011, 7'b1111111, 7'b0110011};
    tick();
    b_in_valid = 1'b0;
    chk("b_sysill_ctrl", b_ctrl, {13'h1000, 13'h1000, 13'h800, 13'h001});
    chk("b_sysill_illegal", b_out_illegal, 1);
    chk("b_sysill_cnt", b_cnt, 1);
    tick();
    chk("b_drained", b_out_valid, 0);

    // Asynchronous reset with one beat buffered
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_op = 7'b0110011;
    tick();
    a_in_valid = 1'b0;
    chk("mid_valid", a_out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", a_out_valid, 0);
    chk("async_cnt", a_cnt, 0);
    chk("async_in_ready", a_in_ready, 0);
    chk("async_ctrl", a_ctrl, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rerst_in_ready", a_in_ready, 1);
    chk("rerst_valid", a_out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
